// File: rtl/even_odd.sv
// ============================================================================
// Module   : even_odd
// Brief    : Registered parity classifier with saturating even/odd tallies.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module even_odd #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] num,
    input  logic             in_valid,
    input  logic             clear,
    output logic             is_even,
    output logic             is_odd,
    output logic             out_valid,
    output logic [CNT_W-1:0] even_count,
    output logic [CNT_W-1:0] odd_count
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    logic             r_is_even;
    logic             r_is_odd;
    logic             r_out_valid;
    logic [CNT_W-1:0] r_even_count;
    logic [CNT_W-1:0] r_odd_count;

    logic             w_take_even;
    logic             w_take_odd;
    logic             w_unused_num;

    // Parity depends only on the LSB; the upper sample bits are don't-care.
    assign w_unused_num = ^num;
    assign w_take_even  = in_valid & ~num[0];
    assign w_take_odd   = in_valid &  num[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_is_even    <= 1'b0;
            r_is_odd     <= 1'b0;
            r_out_valid  <= 1'b0;
            r_even_count <= '0;
            r_odd_count  <= '0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_is_even <= ~num[0];
                r_is_odd  <=  num[0];
            end

            // A clear restarts both tallies, but a same-cycle sample still counts.
            if (clear) begin
                r_even_count <= CNT_W'(w_take_even);
                r_odd_count  <= CNT_W'(w_take_odd);
            end else begin
                if (w_take_even && (r_even_count != c_CNT_MAX)) begin
                    r_even_count <= r_even_count + c_CNT_ONE;
                end
                if (w_take_odd && (r_odd_count != c_CNT_MAX)) begin
                    r_odd_count <= r_odd_count + c_CNT_ONE;
                end
            end
        end
    end

    assign is_even    = r_is_even;
    assign is_odd     = r_is_odd;
    assign out_valid  = r_out_valid;
    assign even_count = r_even_count;
    assign odd_count  = r_odd_count;

endmodule

`default_nettype wire

// File: tb/tb_even_odd.sv
// ============================================================================
// Module   : tb_even_odd
// Brief    : Table-driven self-checking bench for even_odd.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_even_odd;

    logic        clk;
    logic        rst_n;

    logic [7:0]  num;
    logic        in_valid;
    logic        clear;
    logic        is_even;
    logic        is_odd;
    logic        out_valid;
    logic [15:0] even_count;
    logic [15:0] odd_count;

    logic [7:0]  s_num;
    logic        s_in_valid;
    logic        s_clear;
    logic        s_is_even;
    logic        s_is_odd;
    logic        s_out_valid;
    logic [1:0]  s_even_count;
    logic [1:0]  s_odd_count;

    int checks = 0;
    int errors = 0;

    even_odd #(.WIDTH(8), .CNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .num        (num),
        .in_valid   (in_valid),
        .clear      (clear),
        .is_even    (is_even),
        .is_odd     (is_odd),
        .out_valid  (out_valid),
        .even_count (even_count),
        .odd_count  (odd_count)
    );

    even_odd #(.WIDTH(8), .CNT_W(2)) dut_sat (
        .clk        (clk),
        .rst_n      (rst_n),
        .num        (s_num),
        .in_valid   (s_in_valid),
        .clear      (s_clear),
        .is_even    (s_is_even),
        .is_odd     (s_is_odd),
        .out_valid  (s_out_valid),
        .even_count (s_even_count),
        .odd_count  (s_odd_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  num;
        logic        in_valid;
        logic        clear;
        logic        exp_even;
        logic        exp_odd;
        logic        exp_valid;
        logic [15:0] exp_ec;
        logic [15:0] exp_oc;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_main(input string tag, input logic e, input logic o, input logic v,
                            input logic [15:0] ec, input logic [15:0] oc);
        chk({tag, " is_even"},    32'(is_even),    32'(e));
        chk({tag, " is_odd"},     32'(is_odd),     32'(o));
        chk({tag, " out_valid"},  32'(out_valid),  32'(v));
        chk({tag, " even_count"}, 32'(even_count), 32'(ec));
        chk({tag, " odd_count"},  32'(odd_count),  32'(oc));
    endtask

    initial begin
        // num, in_valid, clear, is_even, is_odd, out_valid, even_count, odd_count
        vecs[0]  = '{8'd4,   1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'd1, 16'd0};
        vecs[1]  = '{8'd7,   1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'd1, 16'd1};
        vecs[2]  = '{8'd10,  1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'd2, 16'd1};
        vecs[3]  = '{8'd99,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd2, 16'd1};
        vecs[4]  = '{8'd0,   1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'd3, 16'd1};
        vecs[5]  = '{8'd1,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd3, 16'd1};
        vecs[6]  = '{8'd1,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd3, 16'd1};
        vecs[7]  = '{8'd255, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'd3, 16'd2};
        vecs[8]  = '{8'd0,   1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd3, 16'd2};
        vecs[9]  = '{8'd2,   1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0, 16'd0};
        vecs[10] = '{8'd3,   1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'd0, 16'd1};
        vecs[11] = '{8'd6,   1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'd1, 16'd0};
        vecs[12] = '{8'd8,   1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'd2, 16'd0};

        rst_n      = 1'b0;
        num        = '0;
        in_valid   = 1'b0;
        clear      = 1'b0;
        s_num      = '0;
        s_in_valid = 1'b0;
        s_clear    = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk_main("reset", 1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            num      = vecs[i].num;
            in_valid = vecs[i].in_valid;
            clear    = vecs[i].clear;
            @(posedge clk);
            #1;
            chk_main($sformatf("v%0d", i), vecs[i].exp_even, vecs[i].exp_odd,
                     vecs[i].exp_valid, vecs[i].exp_ec, vecs[i].exp_oc);
        end
        @(negedge clk);
        in_valid = 1'b0;
        clear    = 1'b0;

        // Saturation on a 2-bit tally: odd sticks at 3, even unaffected.
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            s_num      = 8'(2 * k - 1);
            s_in_valid = 1'b1;
            @(posedge clk);
            #1;
            chk($sformatf("sat%0d odd_count", k), 32'(s_odd_count), (k > 3) ? 32'd3 : 32'(k));
            chk($sformatf("sat%0d even_count", k), 32'(s_even_count), 32'd0);
            chk($sformatf("sat%0d is_odd", k), 32'(s_is_odd), 32'd1);
        end
        @(negedge clk);
        s_num = 8'd12;
        @(posedge clk);
        #1;
        chk("sat even after odd sat", 32'(s_even_count), 32'd1);
        chk("sat odd held", 32'(s_odd_count), 32'd3);
        @(negedge clk);
        s_in_valid = 1'b0;

        // Mid-stream async reset with a sample in flight.
        @(negedge clk);
        num      = 8'd9;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("pre-rst is_odd", 32'(is_odd), 32'd1);
        chk("pre-rst odd_count", 32'(odd_count), 32'd1);
        num = 8'd5;
        #1;
        rst_n = 1'b0;
        #1;
        chk_main("async rst", 1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
        chk("async rst sat odd_count", 32'(s_odd_count), 32'd0);
        @(posedge clk);
        #1;
        chk_main("rst held", 1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk);
        #1;
        chk_main("post-rst idle", 1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
        @(negedge clk);
        num      = 8'd2;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        chk_main("post-rst first", 1'b1, 1'b0, 1'b1, 16'd1, 16'd0);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk_main("post-rst idle2", 1'b1, 1'b0, 1'b0, 16'd1, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
